// File: rtl/common_types_pkg.sv
// Shared AHB-Lite encodings for satellites on the bus mux.
// Contents: transfer size codes, response codes, transfer type codes.
package common_types_pkg;

    localparam logic [2:0] HSIZE_BYTE    = 3'd0;
    localparam logic [2:0] HSIZE_HALF    = 3'd1;
    localparam logic [2:0] HSIZE_WORD    = 3'd2;

    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

endpackage

// File: rtl/ahb_bus_if.sv
// AHB-Lite link between the bus mux and one satellite.
//   satellite_to_mux : satellite view (address/data phase in, hrdata/hreadyout/hresp out)
//   mux_to_satellite : mux view (mirror of the above)
interface ahb_bus_if;

    logic [31:0] haddr;
    logic [2:0]  hburst;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic        hwrite;
    logic        hsel;
    logic        hready;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;

    modport satellite_to_mux (
        input  haddr, hburst, hsize, htrans, hwdata, hwrite, hsel, hready,
        output hrdata, hreadyout, hresp
    );

    modport mux_to_satellite (
        output haddr, hburst, hsize, htrans, hwdata, hwrite, hsel, hready,
        input  hrdata, hreadyout, hresp
    );

endinterface

// File: rtl/sram_1r1w.sv
// Byte-writable SRAM, one write port and one synchronous read port.
//   clk          : clock
//   we/waddr/wbe/wdata : write port, byte lanes gated by wbe
//   re/raddr     : read request, data appears on rdata after the edge
//   rdata        : registered read data; holds when re is low
// A read and write to the same word on one edge returns the old data.
module sram_1r1w #(
    parameter  int unsigned DEPTH_WORDS = 4096,
    localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    wbe,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ahb_sram.sv
// AHB-Lite satellite wrapping a byte-writable on-chip SRAM.
//   CLK, nRST : clock, asynchronous active-low reset
//   abus      : ahb_bus_if.satellite_to_mux (address/data phases in, hrdata/hreadyout/hresp out)
// Parameters: DEPTH_WORDS (power of two, >= 4), WAIT_STATES (0..15).
// Build option: define AHB_SRAM_ERR_EN to flag illegal accesses with a two-cycle
// ERROR response; otherwise hresp is always OKAY and addresses wrap.
module ahb_sram
    import common_types_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  CLK,
    input  logic                  nRST,
    ahb_bus_if.satellite_to_mux   abus
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

`ifdef AHB_SRAM_ERR_EN
    typedef enum logic [1:0] {DATA_IDLE, DATA_WAIT, ERR1, ERR2} state_e;
`else
    typedef enum logic {DATA_IDLE, DATA_WAIT} state_e;
`endif

    // Natural AHB lane placement; size 3 falls through to a full word.
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] a);
        case (size)
            HSIZE_BYTE: byte_en = 4'b0001 << a;
            HSIZE_HALF: byte_en = a[1] ? 4'b1100 : 4'b0011;
            default:    byte_en = 4'b1111;
        endcase
    endfunction

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          hreadyout_q, hreadyout_d;
    logic          wr_pend_q, wr_pend_d;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_phase_q, rd_phase_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [3:0]    fwd_be_q, fwd_be_d;
    logic [31:0]   fwd_data_q, fwd_data_d;
    logic [31:0]   hrdata_q, hrdata_d;

    logic          accept, acc_ok;
    logic          wr_commit, wait_exit, rd_now, rd_late, rd_issue;
    logic [AW-1:0] word_addr, rd_addr;
    logic [31:0]   sram_rdata, merged;

    assign accept    = abus.hsel && abus.hready &&
                       (abus.htrans == HTRANS_NONSEQ || abus.htrans == HTRANS_SEQ);
    assign word_addr = abus.haddr[AW+1:2];

`ifdef AHB_SRAM_ERR_EN
    logic illegal;
    logic hresp_q, hresp_d;
    assign illegal = (abus.hsize == 3'd3) ||
                     (abus.hsize == HSIZE_HALF && abus.haddr[0]) ||
                     (abus.hsize == HSIZE_WORD && abus.haddr[1:0] != 2'b00) ||
                     (abus.haddr[31:AW+2] != '0);
    assign acc_ok    = accept && !illegal;
    assign abus.hresp = hresp_q;
`else
    assign acc_ok    = accept;
    assign abus.hresp = HRESP_OKAY;
`endif

    // A write commits on the edge that ends its data phase.
    assign wr_commit = wr_pend_q && hreadyout_q;
    assign wait_exit = (state_q == DATA_WAIT) && (cnt_q == 4'd1);
    // Zero-wait reads hit the SRAM on the accept edge; waited reads are
    // deferred to the last wait edge so earlier commits are visible.
    assign rd_now    = acc_ok && !abus.hwrite && (WAIT_STATES == 0);
    assign rd_late   = wait_exit && rd_pend_q;
    assign rd_issue  = rd_now || rd_late;
    assign rd_addr   = rd_now ? word_addr : addr_q;

    always_comb begin
        merged = sram_rdata;
        for (int unsigned i = 0; i < 4; i++) begin
            if (fwd_be_q[i]) merged[8*i +: 8] = fwd_data_q[8*i +: 8];
        end
    end

    assign abus.hrdata    = rd_phase_q ? merged : hrdata_q;
    assign abus.hreadyout = hreadyout_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hreadyout_d = hreadyout_q;
`ifdef AHB_SRAM_ERR_EN
        hresp_d     = hresp_q;
`endif
        wr_pend_d   = wr_commit ? 1'b0 : wr_pend_q;
        rd_pend_d   = rd_late ? 1'b0 : rd_pend_q;
        addr_d      = addr_q;
        be_d        = be_q;
        rd_phase_d  = rd_issue ? 1'b1 : (hreadyout_q ? 1'b0 : rd_phase_q);
        fwd_be_d    = fwd_be_q;
        fwd_data_d  = fwd_data_q;
        hrdata_d    = (rd_phase_q && hreadyout_q) ? merged : hrdata_q;

        if (rd_issue) begin
            fwd_be_d   = (wr_commit && addr_q == rd_addr) ? be_q : 4'b0000;
            fwd_data_d = abus.hwdata;
        end

        if (acc_ok) begin
            addr_d    = word_addr;
            be_d      = byte_en(abus.hsize, abus.haddr[1:0]);
            wr_pend_d = abus.hwrite;
            rd_pend_d = !abus.hwrite && (WAIT_STATES != 0);
        end

        case (state_q)
            DATA_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d     = DATA_IDLE;
                    hreadyout_d = 1'b1;
                end
            end
`ifdef AHB_SRAM_ERR_EN
            ERR1: begin
                state_d     = ERR2;
                hreadyout_d = 1'b1;
                hresp_d     = HRESP_ERROR;
            end
`endif
            // DATA_IDLE and ERR2 both take a fresh address phase.
            default: begin
                state_d     = DATA_IDLE;
                hreadyout_d = 1'b1;
`ifdef AHB_SRAM_ERR_EN
                hresp_d     = HRESP_OKAY;
                if (accept && illegal) begin
                    state_d     = ERR1;
                    hreadyout_d = 1'b0;
                    hresp_d     = HRESP_ERROR;
                end
`endif
                if (acc_ok && WAIT_STATES != 0) begin
                    state_d     = DATA_WAIT;
                    cnt_d       = 4'(WAIT_STATES);
                    hreadyout_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= DATA_IDLE;
            cnt_q       <= '0;
            hreadyout_q <= 1'b1;
`ifdef AHB_SRAM_ERR_EN
            hresp_q     <= HRESP_OKAY;
`endif
            wr_pend_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_phase_q  <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            fwd_be_q    <= '0;
            fwd_data_q  <= '0;
            hrdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hreadyout_q <= hreadyout_d;
`ifdef AHB_SRAM_ERR_EN
            hresp_q     <= hresp_d;
`endif
            wr_pend_q   <= wr_pend_d;
            rd_pend_q   <= rd_pend_d;
            rd_phase_q  <= rd_phase_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            fwd_be_q    <= fwd_be_d;
            fwd_data_q  <= fwd_data_d;
            hrdata_q    <= hrdata_d;
        end
    end

    sram_1r1w #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_sram (
        .clk   (CLK),
        .we    (wr_commit),
        .waddr (addr_q),
        .wbe   (be_q),
        .wdata (abus.hwdata),
        .re    (rd_issue),
        .raddr (rd_addr),
        .rdata (sram_rdata)
    );

endmodule

// File: tb/tb_ahb_sram.sv
// Bench for ahb_sram: unit 0 (4096 words, no wait states) and unit 1 (64 words,
// 3 wait states) share clock and reset. Transfers are pushed as commands; a
// small reference model produces the expected response when a transfer is
// accepted and the check happens when the data phase completes.
module tb_ahb_sram;
    import common_types_pkg::*;

    localparam int unsigned D0 = 4096;
    localparam int unsigned D1 = 64;
    localparam int unsigned W0 = 0;
    localparam int unsigned W1 = 3;

    typedef struct packed {
        logic        write;
        logic        sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic        is_read;
        logic [31:0] rdata;
        logic        resp;
        int          waits;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] t_addr  [2];
    logic [2:0]  t_size  [2];
    logic [1:0]  t_trans [2];
    logic [31:0] t_wdata [2];
    logic        t_write [2];
    logic        t_sel   [2];

    ahb_bus_if b0();
    ahb_bus_if b1();

    assign b0.haddr  = t_addr[0];  assign b1.haddr  = t_addr[1];
    assign b0.hsize  = t_size[0];  assign b1.hsize  = t_size[1];
    assign b0.htrans = t_trans[0]; assign b1.htrans = t_trans[1];
    assign b0.hwdata = t_wdata[0]; assign b1.hwdata = t_wdata[1];
    assign b0.hwrite = t_write[0]; assign b1.hwrite = t_write[1];
    assign b0.hsel   = t_sel[0];   assign b1.hsel   = t_sel[1];
    assign b0.hburst = 3'b001;     assign b1.hburst = 3'b011;
    assign b0.hready = b0.hreadyout;
    assign b1.hready = b1.hreadyout;

    ahb_sram #(.DEPTH_WORDS(D0), .WAIT_STATES(W0)) dut0 (.CLK(clk), .nRST(rst_n), .abus(b0));
    ahb_sram #(.DEPTH_WORDS(D1), .WAIT_STATES(W1)) dut1 (.CLK(clk), .nRST(rst_n), .abus(b1));

    cmd_t        cmd_q[$];
    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] mdl [2][D0];
    logic [31:0] last_rd [2];
    int unsigned depth [2] = '{D0, D1};
    int          waitst [2] = '{int'(W0), int'(W1)};

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic sample(input int u, output logic rdy, output logic resp, output logic [31:0] rd);
        if (u == 0) begin rdy = b0.hreadyout; resp = b0.hresp; rd = b0.hrdata; end
        else        begin rdy = b1.hreadyout; resp = b1.hresp; rd = b1.hrdata; end
    endtask

    task automatic push(input logic w, input logic s, input logic [1:0] tr,
                        input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        cmd_t c;
        c.write = w; c.sel = s; c.trans = tr; c.addr = a; c.size = sz; c.wdata = d;
        cmd_q.push_back(c);
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        push(1'b1, 1'b1, HTRANS_NONSEQ, a, sz, d);
    endtask

    task automatic rd(input logic [31:0] a, input logic [2:0] sz);
        push(1'b0, 1'b1, HTRANS_NONSEQ, a, sz, 32'hFFFF_FFFF);
    endtask

    task automatic drive_addr(input int u, output logic have, output cmd_t c);
        if (cmd_q.size() > 0) begin
            c = cmd_q.pop_front();
            have = 1'b1;
        end else begin
            c = '0;
            have = 1'b0;
        end
        t_addr[u]  = c.addr;
        t_size[u]  = c.size;
        t_trans[u] = c.trans;
        t_write[u] = c.write;
        t_sel[u]   = c.sel;
    endtask

    function automatic logic lane_on(input logic [2:0] sz, input logic [1:0] a, input int i);
        case (sz)
            HSIZE_BYTE: return i == int'(a);
            HSIZE_HALF: return (i / 2) == int'(a[1]);
            default:    return 1'b1;
        endcase
    endfunction

    task automatic model_accept(input int u, input cmd_t c, output exp_t e);
        logic        ill;
        logic [2:0]  sz;
        int unsigned w;
`ifdef AHB_SRAM_ERR_EN
        ill = (c.size == 3'd3) || (c.size == HSIZE_HALF && c.addr[0]) ||
              (c.size == HSIZE_WORD && c.addr[1:0] != 2'b00) || (c.addr >= depth[u] * 4);
`else
        ill = 1'b0;
`endif
        sz = (c.size == 3'd3) ? HSIZE_WORD : c.size;
        w  = (c.addr >> 2) % depth[u];
        e.resp    = ill;
        e.waits   = ill ? 1 : waitst[u];
        e.is_read = !c.write && !ill;
        e.rdata   = '0;
        if (!ill) begin
            if (c.write) begin
                for (int i = 0; i < 4; i++)
                    if (lane_on(sz, c.addr[1:0], i)) mdl[u][w][8*i +: 8] = c.wdata[8*i +: 8];
            end else begin
                e.rdata = mdl[u][w];
            end
        end
    endtask

    // Plays the queued commands on unit u with pipelined address/data phases.
    task automatic run(input int u, input string tag);
        cmd_t        cur;
        exp_t        e;
        logic        have, dph, done, rdy, resp;
        logic [31:0] rdata;
        int          seen, cyc;
        dph = 1'b0; done = 1'b0; seen = 0; cyc = 0;
        @(posedge clk); #1;
        drive_addr(u, have, cur);
        while (!done && cyc < 400) begin
            @(negedge clk);
            sample(u, rdy, resp, rdata);
            if (dph) begin
                e = exp_q[0];
                checks++;
                if (resp !== e.resp) begin
                    failures++;
                    $display("FAIL %s u%0d resp: got %b want %b", tag, u, resp, e.resp);
                end
                if (!e.is_read) begin
                    checks++;
                    if (rdata !== last_rd[u]) begin
                        failures++;
                        $display("FAIL %s u%0d hrdata_hold: got %h want %h", tag, u, rdata, last_rd[u]);
                    end
                end
                if (rdy) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (seen !== e.waits) begin
                        failures++;
                        $display("FAIL %s u%0d wait_cycles: got %0d want %0d", tag, u, seen, e.waits);
                    end
                    if (e.is_read) begin
                        checks++;
                        if (rdata !== e.rdata) begin
                            failures++;
                            $display("FAIL %s u%0d hrdata: got %h want %h", tag, u, rdata, e.rdata);
                        end
                        last_rd[u] = e.rdata;
                    end
                end else begin
                    seen++;
                end
            end else begin
                checks++;
                if (rdy !== 1'b1 || resp !== HRESP_OKAY || rdata !== last_rd[u]) begin
                    failures++;
                    $display("FAIL %s u%0d idle: got rdy=%b resp=%b rd=%h want rdy=1 resp=0 rd=%h",
                             tag, u, rdy, resp, rdata, last_rd[u]);
                end
            end
            done = !have && (cmd_q.size() == 0) && (!dph || rdy);
            @(posedge clk); #1;
            if (dph && rdy) dph = 1'b0;
            if (rdy && have) begin
                if (cur.sel && cur.trans[1]) begin
                    model_accept(u, cur, e);
                    exp_q.push_back(e);
                    dph = 1'b1;
                    seen = 0;
                    t_wdata[u] = cur.wdata;
                end
                drive_addr(u, have, cur);
            end
            cyc++;
        end
        checks++;
        if (!done || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s u%0d completion: got done=%b pending=%0d want done=1 pending=0",
                     tag, u, done, exp_q.size());
        end
        exp_q.delete();
        cmd_q.delete();
    endtask

    task automatic test_reset();
        logic rdy, resp;
        logic [31:0] rdata;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            sample(u, rdy, resp, rdata);
            checks += 3;
            if (rdy !== 1'b1) begin failures++; $display("FAIL reset u%0d hreadyout: got %b want 1", u, rdy); end
            if (resp !== 1'b0) begin failures++; $display("FAIL reset u%0d hresp: got %b want 0", u, resp); end
            if (rdata !== 32'h0) begin failures++; $display("FAIL reset u%0d hrdata: got %h want 0", u, rdata); end
            last_rd[u] = '0;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        wr(32'h10, HSIZE_WORD, 32'hDEAD_BEEF);
        rd(32'h10, HSIZE_WORD);
        wr(32'h14, HSIZE_WORD, 32'h0123_4567);
        rd(32'h14, HSIZE_WORD);
        rd(32'h10, HSIZE_WORD);
        run(0, "write_read");
    endtask

    task automatic test_forwarding();
        wr(32'h20, HSIZE_WORD, 32'h1122_3344);
        wr(32'h21, HSIZE_BYTE, 32'h5A5A_AB5A);
        rd(32'h20, HSIZE_WORD);
        wr(32'h24, HSIZE_WORD, 32'h0102_0304);
        wr(32'h26, HSIZE_HALF, 32'hBEEF_1234);
        rd(32'h24, HSIZE_WORD);
        wr(32'h2B, HSIZE_BYTE, 32'hC3_000000);
        rd(32'h28, HSIZE_BYTE);
        wr(32'h30, HSIZE_WORD, 32'hAAAA_5555);
        rd(32'h20, HSIZE_WORD);
        run(0, "forwarding");
    endtask

    task automatic test_idle_busy();
        push(1'b1, 1'b1, HTRANS_IDLE,   32'h10, HSIZE_WORD, 32'h0);
        push(1'b1, 1'b1, HTRANS_BUSY,   32'h10, HSIZE_WORD, 32'h0);
        push(1'b1, 1'b0, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 32'h0);
        push(1'b1, 1'b1, HTRANS_SEQ,    32'h18, HSIZE_WORD, 32'h7777_8888);
        rd(32'h10, HSIZE_WORD);
        rd(32'h18, HSIZE_WORD);
        run(0, "idle_busy");
    endtask

    task automatic test_wait_states();
        wr(32'h04, HSIZE_WORD, 32'hCAFE_F00D);
        rd(32'h04, HSIZE_WORD);
        wr(32'h05, HSIZE_BYTE, 32'h0000_7700);
        rd(32'h04, HSIZE_WORD);
        wr(32'h08, HSIZE_HALF, 32'h0000_9ABC);
        rd(32'h04, HSIZE_WORD);
        run(1, "wait_states");
    endtask

    task automatic test_error();
`ifdef AHB_SRAM_ERR_EN
        wr(32'h00, HSIZE_WORD, 32'h0BAD_C0DE);
        rd(32'h02, HSIZE_WORD);
        wr(32'h4000, HSIZE_WORD, 32'h1234_5678);
        wr(32'h01, HSIZE_HALF, 32'hFFFF_FFFF);
        push(1'b1, 1'b1, HTRANS_NONSEQ, 32'h00, 3'd3, 32'hFFFF_FFFF);
        rd(32'h00, HSIZE_WORD);
        run(0, "error");
        wr(32'h00, HSIZE_WORD, 32'h600D_F00D);
        rd(32'h41, HSIZE_WORD);
        wr(32'h100, HSIZE_WORD, 32'h1234_5678);
        rd(32'h00, HSIZE_WORD);
        run(1, "error_wait");
`else
        wr(32'h00, HSIZE_WORD, 32'h0BAD_C0DE);
        wr(32'h4000, HSIZE_WORD, 32'h1234_5678);
        rd(32'h00, HSIZE_WORD);
        wr(32'h02, HSIZE_WORD, 32'h8765_4321);
        rd(32'h00, HSIZE_WORD);
        push(1'b1, 1'b1, HTRANS_NONSEQ, 32'h04, 3'd3, 32'h5566_7788);
        rd(32'h04, HSIZE_WORD);
        run(0, "wrap");
        wr(32'h00, HSIZE_WORD, 32'h600D_F00D);
        wr(32'h104, HSIZE_WORD, 32'h1357_9BDF);
        rd(32'h04, HSIZE_WORD);
        run(1, "wrap_wait");
`endif
    endtask

    task automatic test_reset_mid();
        logic rdy, resp;
        logic [31:0] rdata;
        wr(32'h0C, HSIZE_WORD, 32'h5566_7788);
        rd(32'h0C, HSIZE_WORD);
        run(1, "reset_mid_setup");
        @(posedge clk); #1;
        t_addr[1] = 32'h0C; t_size[1] = HSIZE_WORD; t_trans[1] = HTRANS_NONSEQ;
        t_write[1] = 1'b1; t_sel[1] = 1'b1;
        @(posedge clk); #1;
        t_wdata[1] = 32'hFFFF_FFFF; t_trans[1] = HTRANS_IDLE; t_sel[1] = 1'b0;
        @(negedge clk);
        sample(1, rdy, resp, rdata);
        checks++;
        if (rdy !== 1'b0) begin failures++; $display("FAIL reset_mid wait_entry: got %b want 0", rdy); end
        #1 rst_n = 1'b0;
        #1 sample(1, rdy, resp, rdata);
        checks += 3;
        if (rdy !== 1'b1) begin failures++; $display("FAIL reset_mid hreadyout: got %b want 1", rdy); end
        if (resp !== 1'b0) begin failures++; $display("FAIL reset_mid hresp: got %b want 0", resp); end
        if (rdata !== 32'h0) begin failures++; $display("FAIL reset_mid hrdata: got %h want 0", rdata); end
        last_rd[0] = '0;
        last_rd[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        rd(32'h0C, HSIZE_WORD);
        run(1, "reset_mid_keep");
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            t_addr[u] = '0; t_size[u] = '0; t_trans[u] = HTRANS_IDLE;
            t_wdata[u] = '0; t_write[u] = 1'b0; t_sel[u] = 1'b0;
            last_rd[u] = '0;
        end
        test_reset();
        test_write_read();
        test_forwarding();
        test_idle_busy();
        test_wait_states();
        test_error();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_sram.md
# ahb_sram

AHB-Lite satellite wrapping an on-chip byte-writable SRAM. It sits on the satellite side of the bus mux and connects through `ahb_bus_if.satellite_to_mux`. It:
- consumes the address and data phases the mux forwards;
- returns read data with configurable wait states;
- forwards in-flight write data to an immediately following read;
- optionally flags illegal accesses with the two-cycle AHB ERROR response.

## Interface
- `DEPTH_WORDS`, default 4096: SRAM depth in 32-bit words. Power of two, ≥ 4.
- `WAIT_STATES`, default 0: extra `hreadyout`-low cycles inserted in every OKAY data phase. Range 0–15.
- `CLK` — input, 1 bit: the single clock. All state updates on the rising edge.
- `nRST` — input, 1 bit: asynchronous, active-low reset.
- `abus` — `ahb_bus_if.satellite_to_mux` interface.
  - Inputs: `haddr`, `hburst`, `hsize`, `htrans`, `hwdata`, `hwrite`, `hsel`, `hready`.
  - Outputs: `hrdata`, `hreadyout`, `hresp`.

## Operation
- Transfer accepted on a rising edge when `hsel && hready && htrans ∈ {NONSEQ, SEQ}`.
  - On acceptance, capture word address `haddr[log2(DEPTH_WORDS)+1:2]`, `haddr[1:0]`, `hsize` and `hwrite`.
- `IDLE` or `BUSY` transfers, or `hsel` low: no access. Next cycle is zero-wait OKAY.
- `hburst` is ignored. Every beat is handled as a single transfer.
- Byte enables come from `hsize` and `haddr[1:0]`:
  - byte: one lane;
  - half: lanes {1:0} or {3:2};
  - word: all four lanes.
- Lane placement is the natural AHB placement. `hrdata` always returns the full word and the controller extracts the lanes it needs.
- State machine, states `DATA_IDLE`, `DATA_WAIT`, `ERR1`, `ERR2`:
  - `DATA_IDLE` + OKAY accept with `WAIT_STATES == 0`: stay in `DATA_IDLE`, `hreadyout = 1`.
  - `DATA_IDLE` + OKAY accept with `WAIT_STATES > 0`: go to `DATA_WAIT`, load counter with `WAIT_STATES`.
  - `DATA_WAIT`: `hreadyout = 0`, counter decrements. At 0, return to `DATA_IDLE`, where the data phase completes with `hreadyout = 1`.
  - Accept of an illegal transfer: `ERR1` (`hreadyout = 0`, `hresp = 1`), then `ERR2` (`hreadyout = 1`, `hresp = 1`), then `DATA_IDLE`.
- Illegal transfer conditions (`AHB_SRAM_ERR_EN` only):
  - `hsize == 3`;
  - half access with `haddr[0] = 1`;
  - word access with `haddr[1:0] ≠ 0`;
  - `haddr ≥ DEPTH_WORDS*4`.
- An errored transfer never writes the SRAM, and `hrdata` is not updated.
- A new address phase accepted while in `ERR2` is processed normally.
- Writes:
  - `hwdata` is sampled on the edge that completes the data phase (`hreadyout = 1`).
  - The write commits to the SRAM on that same edge, with the captured byte enables.
- Reads:
  - The SRAM read is issued on the acceptance edge; the result is held in a register until the data phase completes.
  - With wait states, the read is issued on the final `DATA_WAIT` edge instead, so that a write committing earlier is seen.
- Read-after-write forwarding:
  - Applies when a read's SRAM access edge coincides with a write commit to the same word.
  - For each enabled write lane, the `hrdata` byte comes from the registered `hwdata`; all other lanes come from the SRAM.
- `hrdata` holds its last value outside read data phases.

## Timing
- Reset values (asynchronous): state `DATA_IDLE`, `hreadyout = 1`, `hresp = 0`, `hrdata = 0`, wait counter 0, no pending write.
- SRAM contents are not reset.
- Read latency, address phase to data valid: `1 + WAIT_STATES` cycles.
- Write: data phase is `1 + WAIT_STATES` cycles; SRAM is updated at the end of the data phase.
- ERROR: always exactly 2 data-phase cycles, independent of `WAIT_STATES`.
- Reset asserted mid-transfer: the pending write is discarded, outputs return to reset values immediately, and no partial write occurs.
- When `hsel` is low, `hresp` is 0 and `hreadyout` is 1 in the next cycle, unless an earlier transfer's data phase is still active.

## Configuration
- `AHB_SRAM_ERR_EN` defined: illegal-transfer detection and the two-cycle ERROR response are compiled in.
- `AHB_SRAM_ERR_EN` undefined:
  - `hresp` is tied to 0 and states `ERR1`/`ERR2` do not exist;
  - misaligned accesses use the enables derived from `haddr[1:0]` with size truncated to word (`hsize == 3` is treated as 2);
  - out-of-range addresses wrap modulo `DEPTH_WORDS`.

## Structure
- `common_types_pkg` gains shared encodings, for reuse by other satellites:
  - `HSIZE_BYTE` / `HSIZE_HALF` / `HSIZE_WORD`;
  - `HRESP_OKAY` / `HRESP_ERROR`.
- The state enum and byte-enable function stay local to `ahb_sram`.
- One sub-module, `sram_1r1w`: byte-enabled, one write port and one synchronous read port, 1-cycle read, old data on a same-edge collision. Forwarding logic lives in `ahb_sram`.

## Test plan
- Reset, then word write 0xDEADBEEF to 0x10, then word read 0x10 with `WAIT_STATES = 0` → `hrdata` = 0xDEADBEEF one cycle after the read address phase, `hresp = 0`.
- Back-to-back: byte write 0xAB to 0x21 immediately followed by word read 0x20, over old word 0x11223344 → read returns 0x1122AB44 via forwarding.
- `WAIT_STATES = 3` word read → `hreadyout` low for exactly 3 cycles, data valid on the 4th cycle.
- Error enabled: word read at 0x02 → cycle 1 `hreadyout = 0`, `hresp = 1`; cycle 2 `hreadyout = 1`, `hresp = 1`; SRAM unchanged.
- Error enabled: write to `DEPTH_WORDS*4` → ERROR pair, no write. Error disabled: same write lands at word 0.
- `nRST` pulsed low during a `DATA_WAIT` write → `hreadyout = 1`, `hrdata = 0` immediately; target word keeps its old value.
